// File: rtl/key_event_scheduler.sv
// key_event_scheduler: turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events
// and serialises them onto one valid/ready stream with round-robin arbitration.
module key_event_scheduler #(
    parameter int N_KEYS     = 4,
    parameter int IDW        = 2,
    parameter int LONG_CNT   = 50,
    parameter int REPEAT_CNT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N_KEYS-1:0] key_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDW-1:0]    evt_key,
    output logic [1:0]        evt_code,
    output logic              ovf,
    input  logic              ovf_clr
);
    typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
    localparam logic [1:0] PRESS = 2'd0, RELEASE = 2'd1, LONG = 2'd2, REPEAT = 2'd3;
    localparam logic [7:0] LONG_M1 = 8'(LONG_CNT - 1);
    localparam logic [7:0] RPT_M1 = 8'(REPEAT_CNT - 1);

    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [7:0]        cnt_q [N_KEYS];
    logic [7:0]        cnt_d [N_KEYS];
    logic [N_KEYS-1:0] emit;
    logic [1:0]        code [N_KEYS];
    logic [N_KEYS-1:0] slot_full_q, slot_full_d, take, drop;
    logic [1:0]        slot_code_q [N_KEYS];
    logic [1:0]        slot_code_d [N_KEYS];
    logic [IDW-1:0]    rr_q, rr_d, gnt_idx, evt_key_q, evt_key_d;
    logic              gnt_vld, load;
    logic              evt_valid_q, evt_valid_d, ovf_q, ovf_d;
    logic [1:0]        evt_code_q, evt_code_d;

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            emit[i]    = 1'b0;
            code[i]    = PRESS;
            case (state_q[i])
                IDLE: if (!key_in[i]) begin
                    emit[i]    = 1'b1;
                    cnt_d[i]   = '0;
                    state_d[i] = HELD;
                end
                HELD: if (key_in[i]) begin
                    emit[i]    = 1'b1;
                    code[i]    = RELEASE;
                    state_d[i] = IDLE;
                end else if (tick) begin
                    emit[i]    = cnt_q[i] == LONG_M1;
                    code[i]    = LONG;
                    cnt_d[i]   = emit[i] ? '0 : cnt_q[i] + 8'd1;
                    state_d[i] = emit[i] ? RPT : HELD;
                end
                RPT: if (key_in[i]) begin
                    emit[i]    = 1'b1;
                    code[i]    = RELEASE;
                    state_d[i] = IDLE;
                end else if (tick) begin
                    emit[i]  = cnt_q[i] == RPT_M1;
                    code[i]  = REPEAT;
                    cnt_d[i] = emit[i] ? '0 : cnt_q[i] + 8'd1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // First full slot at or after the round-robin pointer, with wrap-around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (!gnt_vld && slot_full_q[(int'(rr_q) + k) % N_KEYS]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'((int'(rr_q) + k) % N_KEYS);
            end
        end
    end

    assign load = !evt_valid_q || evt_ready;
    assign take = (load && gnt_vld) ? (N_KEYS'(1) << gnt_idx) : '0;

    // A slot being drained on this edge can accept a new event without loss.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            drop[i]        = emit[i] && slot_full_q[i] && !take[i];
            slot_full_d[i] = emit[i] || (slot_full_q[i] && !take[i]);
            slot_code_d[i] = (emit[i] && !drop[i]) ? code[i] : slot_code_q[i];
        end
        ovf_d       = |drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        evt_valid_d = load ? gnt_vld : evt_valid_q;
        evt_key_d   = (load && gnt_vld) ? gnt_idx : evt_key_q;
        evt_code_d  = (load && gnt_vld) ? slot_code_q[gnt_idx] : evt_code_q;
        rr_d        = (load && gnt_vld) ? ((gnt_idx == IDW'(N_KEYS - 1)) ? '0 : gnt_idx + IDW'(1)) : rr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i]     <= IDLE;
                cnt_q[i]       <= '0;
                slot_code_q[i] <= PRESS;
            end
            slot_full_q <= '0;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_code_q  <= PRESS;
            ovf_q       <= 1'b0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                slot_code_q[i] <= slot_code_d[i];
            end
            slot_full_q <= slot_full_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_code_q  <= evt_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_code  = evt_code_q;
    assign ovf       = ovf_q;
endmodule
